// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable integer clock divider.
// Each channel emits a registered divided clock, a tick strobe and an active flag.
module clk_div_multi #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH*DIV_W-1:0]   div_val,
    input  logic [NUM_CH-1:0]         div_load,
    input  logic                      sync_start,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         active
);

    localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
    localparam logic [DIV_W:0]   ONE_W = (DIV_W+1)'(1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            logic [DIV_W-1:0] n_q, n_d;
            logic [DIV_W-1:0] p_q, p_d;
            logic [DIV_W-1:0] k_q, k_d;
            logic             pend_q, pend_d;
            logic             st_q, st_d;
            logic [DIV_W-1:0] ld_val;
            logic [DIV_W:0]   half;
            logic             bnd;
            logic             co_q, tk_q, ac_q;

            always_comb begin
                ld_val = div_val[g*DIV_W +: DIV_W];
                if (ld_val < TWO) begin
                    ld_val = TWO;
                end
            end

            assign bnd = (k_q == (n_q - ONE));

            always_comb begin
                n_d    = n_q;
                p_d    = p_q;
                k_d    = k_q;
                pend_d = pend_q;
                st_d   = st_q;
                if (sync_start && en[g]) begin
                    // restart in phase; a same-cycle load beats any pending value
                    if (div_load[g]) begin
                        n_d = ld_val;
                    end else if (pend_q) begin
                        n_d = p_q;
                    end
                    pend_d = 1'b0;
                    k_d    = '0;
                    st_d   = ST_RUN;
                end else if (st_q == ST_IDLE) begin
                    if (div_load[g]) begin
                        n_d = ld_val;
                    end
                    if (en[g]) begin
                        k_d  = '0;
                        st_d = ST_RUN;
                    end
                end else if (bnd) begin
                    if (pend_q) begin
                        n_d = p_q;
                    end
                    pend_d = 1'b0;
                    if (div_load[g]) begin
                        p_d    = ld_val;
                        pend_d = 1'b1;
                    end
                    k_d  = '0;
                    st_d = en[g] ? ST_RUN : ST_IDLE;
                end else begin
                    k_d = k_q + ONE;
                    if (div_load[g]) begin
                        p_d    = ld_val;
                        pend_d = 1'b1;
                    end
                end
            end

            assign half = ({1'b0, n_d} + ONE_W) >> 1;

            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    n_q    <= DEF_N;
                    p_q    <= DEF_N;
                    k_q    <= '0;
                    pend_q <= 1'b0;
                    st_q   <= ST_IDLE;
                    co_q   <= 1'b0;
                    tk_q   <= 1'b0;
                    ac_q   <= 1'b0;
                end else begin
                    n_q    <= n_d;
                    p_q    <= p_d;
                    k_q    <= k_d;
                    pend_q <= pend_d;
                    st_q   <= st_d;
                    co_q   <= (st_d == ST_RUN) && ({1'b0, k_d} < half);
                    tk_q   <= (st_d == ST_RUN) && (k_d == '0);
                    ac_q   <= (st_d == ST_RUN);
                end
            end

            assign clk_out[g] = co_q;
            assign tick[g]    = tk_q;
            assign active[g]  = ac_q;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: vector table, directed corner
// sequences and randomized traffic against a period-queue reference model.
module tb_clk_div_multi;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [1:0]  en;
    logic [15:0] div_val;
    logic [1:0]  div_load;
    logic        sync_start;
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [1:0]  active;

    clk_div_multi #(.NUM_CH(2), .DIV_W(8), .DEFAULT_DIV(4)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .div_val   (div_val),
        .div_load  (div_load),
        .sync_start(sync_start),
        .clk_out   (clk_out),
        .tick      (tick),
        .active    (active)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: each running channel holds the remaining waveform
    // bits of its current period in a queue
    int m_n[2];
    int m_p[2];
    bit m_pend[2];
    bit m_run[2];
    bit m_wq[2][$];
    int m_len[2];

    typedef struct {
        bit e;
        bit l;
        int d;
        bit c;
        bit t;
        bit a;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 4;
            m_p[i] = 4;
            m_pend[i] = 0;
            m_run[i] = 0;
            m_wq[i].delete();
            m_len[i] = 0;
        end
    endfunction

    function automatic void m_start(input int i);
        m_wq[i].delete();
        for (int j = 0; j < m_n[i]; j++) m_wq[i].push_back(2 * j < m_n[i]);
        m_len[i] = m_n[i];
        m_run[i] = 1;
    endfunction

    function automatic void m_update();
        for (int i = 0; i < 2; i++) begin
            bit ld;
            int v;
            ld = div_load[i];
            v = clampv(int'(div_val[i*8 +: 8]));
            if (sync_start && en[i]) begin
                if (ld) m_n[i] = v;
                else if (m_pend[i]) m_n[i] = m_p[i];
                m_pend[i] = 0;
                m_start(i);
            end else if (!m_run[i]) begin
                if (ld) m_n[i] = v;
                if (en[i]) m_start(i);
            end else if (m_wq[i].size() == 1) begin
                if (m_pend[i]) m_n[i] = m_p[i];
                m_pend[i] = 0;
                if (ld) begin
                    m_p[i] = v;
                    m_pend[i] = 1;
                end
                if (en[i]) m_start(i);
                else begin
                    m_run[i] = 0;
                    m_wq[i].delete();
                end
            end else begin
                void'(m_wq[i].pop_front());
                if (ld) begin
                    m_p[i] = v;
                    m_pend[i] = 1;
                end
            end
        end
    endfunction

    task automatic step(input logic [1:0] e, input logic [1:0] ld,
                        input int d0, input int d1, input logic s);
        en = e;
        div_load = ld;
        div_val = {d1[7:0], d0[7:0]};
        sync_start = s;
        @(posedge clk_in);
        m_update();
        #1;
        for (int i = 0; i < 2; i++) begin
            int ec;
            int et;
            ec = m_run[i] ? int'(m_wq[i][0]) : 0;
            et = (m_run[i] && m_wq[i].size() == m_len[i]) ? 1 : 0;
            chk($sformatf("model clk_out[%0d]", i), int'(clk_out[i]), ec);
            chk($sformatf("model tick[%0d]", i), int'(tick[i]), et);
            chk($sformatf("model active[%0d]", i), int'(active[i]), int'(m_run[i]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = '0;
        div_load = '0;
        div_val = '0;
        sync_start = 1'b0;
        m_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        chk("reset clk_out", int'(clk_out), 0);
        chk("reset tick", int'(tick), 0);
        chk("reset active", int'(active), 0);
        rst_n = 1'b1;
    endtask

    function automatic void tv(input bit e, input bit l, input int d,
                               input bit c, input bit t, input bit a);
        vec_t r;
        r.e = e; r.l = l; r.d = d; r.c = c; r.t = t; r.a = a;
        tbl.push_back(r);
    endfunction

    function automatic void tv_pat(input string pat, input int reps);
        for (int r = 0; r < reps; r++)
            for (int j = 0; j < pat.len(); j++)
                tv(1, 0, 0, pat[j] == "1", j == 0, 1);
    endfunction

    initial begin
        int tk[$];
        int cnt0;
        int cnt1;
        bit coinc;
        bit ex_c[6];
        bit ex_a[6];

        // test plan items 1 and 2 as a vector table on channel 0
        tv_pat("1100", 2);
        tv(0, 0, 0, 0, 0, 0);
        tv(0, 1, 5, 0, 0, 0);
        tv_pat("11100", 2);
        tv(0, 0, 0, 0, 0, 0);
        tv(0, 1, 0, 0, 0, 0);
        tv_pat("10", 2);
        tv(0, 0, 0, 0, 0, 0);
        tv(0, 1, 1, 0, 0, 0);
        tv_pat("10", 2);
        tv(0, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step({1'b0, tbl[i].e}, {1'b0, tbl[i].l}, tbl[i].d, 0, 1'b0);
            chk($sformatf("tbl[%0d] clk_out", i), int'(clk_out[0]), int'(tbl[i].c));
            chk($sformatf("tbl[%0d] tick", i), int'(tick[0]), int'(tbl[i].t));
            chk($sformatf("tbl[%0d] active", i), int'(active[0]), int'(tbl[i].a));
        end

        // divisor change to 6 while running at k=1
        do_reset();
        tk.delete();
        for (int c = 0; c < 17; c++) begin
            step(2'b01, (c == 2) ? 2'b01 : 2'b00, 6, 0, 1'b0);
            if (tick[0]) tk.push_back(c);
        end
        chk("reload tick count", tk.size(), 4);
        if (tk.size() == 4) begin
            chk("reload gap0", tk[1] - tk[0], 4);
            chk("reload gap1", tk[2] - tk[1], 6);
            chk("reload gap2", tk[3] - tk[2], 6);
        end

        // N=8 stop requested at k=2 must finish the period
        do_reset();
        step(2'b00, 2'b01, 8, 0, 1'b0);
        for (int c = 0; c < 3; c++) step(2'b01, 2'b00, 0, 0, 1'b0);
        ex_c = '{1, 0, 0, 0, 0, 0};
        ex_a = '{1, 1, 1, 1, 1, 0};
        for (int c = 0; c < 6; c++) begin
            step(2'b00, 2'b00, 0, 0, 1'b0);
            chk($sformatf("stop clk_out k=%0d", c + 3), int'(clk_out[0]), int'(ex_c[c]));
            chk($sformatf("stop active k=%0d", c + 3), int'(active[0]), int'(ex_a[c]));
        end

        // sync of N=3 and N=6 channels started out of phase
        do_reset();
        step(2'b00, 2'b11, 3, 6, 1'b0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        for (int c = 0; c < 4; c++) step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b1);
        chk("sync tick both", int'(tick), 3);
        cnt0 = int'(tick[0]);
        cnt1 = int'(tick[1]);
        coinc = 1;
        for (int c = 1; c < 12; c++) begin
            step(2'b11, 2'b00, 0, 0, 1'b0);
            cnt0 += int'(tick[0]);
            cnt1 += int'(tick[1]);
            if (tick[1] && !tick[0]) coinc = 0;
        end
        chk("sync ch0 ticks", cnt0, 4);
        chk("sync ch1 ticks", cnt1, 2);
        chk("sync coincident", int'(coinc), 1);

        // asynchronous reset in the middle of a high phase
        do_reset();
        step(2'b00, 2'b01, 6, 0, 1'b0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async rst clk_out", int'(clk_out[0]), 0);
        chk("async rst active", int'(active[0]), 0);
        m_reset();
        en = '0;
        @(negedge clk_in);
        rst_n = 1'b1;
        ex_c = '{1, 1, 0, 0, 1, 1};
        for (int c = 0; c < 6; c++) begin
            step(2'b01, 2'b00, 0, 0, 1'b0);
            chk($sformatf("post rst clk_out %0d", c), int'(clk_out[0]), int'(ex_c[c]));
        end

        // randomized traffic on both channels
        do_reset();
        begin
            logic [1:0] e;
            e = 2'b11;
            for (int c = 0; c < 800; c++) begin
                logic [1:0] ld;
                int d0;
                int d1;
                for (int i = 0; i < 2; i++)
                    if ($urandom_range(0, 15) == 0) e[i] = ~e[i];
                ld[0] = ($urandom_range(0, 9) == 0);
                ld[1] = ($urandom_range(0, 9) == 0);
                d0 = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
                d1 = $urandom_range(0, 9);
                step(e, ld, d0, d1, $urandom_range(0, 39) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Multi-channel, runtime-programmable integer clock divider. It generates NUM_CH divided clocks from one source clock, with per-channel divisors of any integer value from 2 to 2^DIV_W-1, odd or even. Each channel also produces a single-cycle tick strobe in the source domain. Divisor changes, enable and disable are glitch-free and take effect only at period boundaries. A sync input phase-aligns all channels. It feeds peripheral clock and strobe generation in the FPGA top level.

Parameters:
NUM_CH, 2, number of independent divider channels (1..8)
DIV_W, 8, width of each channel divisor field
DEFAULT_DIV, 4, divisor loaded into every channel at reset (2..2^DIV_W-1)

Ports:
clk_in  input  1  source clock; all logic on its rising edge
rst_n  input  1  reset, asynchronous, active-low
en  input  NUM_CH  per-channel run enable, level
div_val  input  NUM_CH*DIV_W  per-channel divisor; channel i uses bits [i*DIV_W +: DIV_W]
div_load  input  NUM_CH  per-channel one-cycle strobe that captures div_val into the pending register
sync_start  input  1  one-cycle strobe that restarts all enabled channels in phase
clk_out  output  NUM_CH  divided clocks, registered
tick  output  NUM_CH  one clk_in-cycle pulse coincident with each clk_out rising edge
active  output  NUM_CH  channel currently producing periods

Behaviour:
- Per-channel state:
  - active divisor N (DIV_W bits)
  - pending divisor P and pending flag
  - phase counter k in 0..N-1
  - run flag
- Reset (async, immediate):
  - clk_out=0, tick=0, active=0, k=0
  - N=P=DEFAULT_DIV, pending flag=0
- Clamp: a captured div_val of 0 or 1 is stored as 2. No divide-by-1 path exists.
- Waveform:
  - clk_out is high for phases k=0..H-1 and low for k=H..N-1, where H=(N+1)>>1 (ceil).
  - Even N gives 50% duty. Odd N is high one cycle longer than low.
  - N=4 gives 1100; N=5 gives 11100.
- Start: en sampled 1 while idle → the next cycle is k=0, with clk_out=1, tick=1 and active=1. Latency from en to the first rising edge is 1 clk_in cycle.
- Period boundary: k==N-1 → next k=0. At that boundary:
  - if the pending flag is set, N←P and the flag clears;
  - the new N governs the next period.
- Load:
  - Idle channel: div_load sets N directly.
  - Running channel: div_load writes P and sets the pending flag.
  - Repeated loads before the boundary overwrite P; the last value wins.
- Stop:
  - en sampled 0 mid-period → the channel completes the current period to k=N-1, then goes idle.
  - Idle means clk_out=0, active=0, k=0.
  - No truncated high or low phase is ever emitted.
  - en re-asserted before the period ends cancels the stop.
- Sync: sync_start → every channel with en=1 restarts at k=0 on the next cycle.
  - A pending P is applied first.
  - The current period may be truncated. sync is the only permitted truncation.
  - Disabled channels are unaffected.
- Simultaneous div_load and sync_start on the same channel: the loaded value is the one used for the restarted period.
- Simultaneous div_load and boundary: the new value becomes P and applies at the following boundary. The previous pending value, if any, applies now.
- Channels are fully independent except for the shared sync_start.
- Counters never exceed N-1; no wrap beyond DIV_W.
- clk_out drives clock-enable or low-skew routing only; tick is the preferred same-domain strobe.

Test Plan:
1. Reset, en[0]=1, DEFAULT_DIV=4 → clk_out[0] reads 1,1,0,0 repeating, starting 1 cycle after en; tick[0] pulses every 4 cycles, aligned with the rising edges.
2. div_load with 5, then 0, then 1 while idle, each followed by a run → 11100 repeating for 5; 10 repeating for both 0 and 1 (clamped to 2).
3. Running with N=4, div_load of 6 at k=1 → the current period completes as 1100; the following periods are 111000; tick spacing changes from 4 to 6 exactly at the boundary.
4. N=8 running, en dropped at k=2 → clk_out stays high through k=3 and low through k=7; active falls after k=7; no pulse is shorter than 4 cycles.
5. ch0 N=3, ch1 N=6, both enabled and out of phase, sync_start pulsed → both tick on the next cycle; thereafter ch0 ticks twice per ch1 tick, with every ch1 tick coincident with a ch0 tick.
6. Assert rst_n low mid-high phase with N=6 loaded → clk_out=0 and active=0 immediately (asynchronous); after release and en, the period is DEFAULT_DIV (1100).
